// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: opcodes, FSM states, word sizes.
package loader_pkg;

    localparam logic [7:0] OP_WRI  = 8'h01;
    localparam logic [7:0] OP_WRD  = 8'h02;
    localparam logic [7:0] OP_RDI  = 8'h03;
    localparam logic [7:0] OP_RDD  = 8'h04;
    localparam logic [7:0] OP_RUN  = 8'h05;
    localparam logic [7:0] OP_HALT = 8'h06;
    localparam logic [7:0] OP_CLR  = 8'h07;

    localparam int IMEM_BYTES = 4;
    localparam int DMEM_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WR,
        ST_RD,
        ST_RDW,
        ST_SEND
    } state_e;

    // True for opcodes that carry an address and touch a memory
    function automatic logic is_mem_op(input logic [7:0] op);
        return (op == OP_WRI) || (op == OP_WRD) || (op == OP_RDI) || (op == OP_RDD);
    endfunction

endpackage

// File: rtl/prog_loader_byte_shift_reg.sv
// Byte-wide shift register: new bytes enter at the top and move toward bit 0,
// or the whole word can be loaded in parallel.
module byte_shift_reg #(
    parameter int BYTES = 8
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 en,
    input  logic                 load,
    input  logic [8*BYTES-1:0]   load_data,
    input  logic [7:0]           shift_in,
    output logic [8*BYTES-1:0]   q
);

    logic [8*BYTES-1:0] data_q;
    logic [8*BYTES-1:0] data_d;
    logic [8*BYTES+7:0] shift_ext;

    // Next value: hold, parallel load, or shift one byte in from the top
    always_comb begin
        data_d    = data_q;
        shift_ext = {shift_in, data_q};
        if (en) begin
            if (load) begin
                data_d = load_data;
            end else begin
                data_d = shift_ext[8*BYTES+7:8];
            end
        end
    end

    // Register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/prog_loader.sv
// Host-side program loader: turns a byte-serial command stream into IMEM/DMEM
// word writes and reads, and controls the CPU run enable.
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_BYTES = 2
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2,
    output logic        cpu_enable,
    output logic        err
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        bad_q, bad_d;
    logic        enable_q, enable_d;
    logic        err_q, err_d;

    logic        addr_shift;
    logic        data_shift;
    logic        rd_load;
    logic        rd_shift;
    logic        is_imem;
    logic        is_write;
    logic [3:0]  last_byte;
    logic [63:0] rd_word;

    logic [8*ADDR_BYTES-1:0] addr_q;
    logic [63:0]             wdata_q;
    logic [63:0]             rdata_q;

    byte_shift_reg #(.BYTES(ADDR_BYTES)) u_addr_sr (
        .clk       (clk),
        .arst_n    (arst_n),
        .en        (addr_shift),
        .load      (1'b0),
        .load_data ('0),
        .shift_in  (in_data),
        .q         (addr_q)
    );

    byte_shift_reg #(.BYTES(DMEM_BYTES)) u_wdata_sr (
        .clk       (clk),
        .arst_n    (arst_n),
        .en        (data_shift),
        .load      (1'b0),
        .load_data ('0),
        .shift_in  (in_data),
        .q         (wdata_q)
    );

    byte_shift_reg #(.BYTES(DMEM_BYTES)) u_rdata_sr (
        .clk       (clk),
        .arst_n    (arst_n),
        .en        (rd_load | rd_shift),
        .load      (rd_load),
        .load_data (rd_word),
        .shift_in  (8'h00),
        .q         (rdata_q)
    );

    assign is_imem   = (cmd_q == OP_WRI) || (cmd_q == OP_RDI);
    assign is_write  = (cmd_q == OP_WRI) || (cmd_q == OP_WRD);
    assign last_byte = is_imem ? 4'(IMEM_BYTES - 1) : 4'(DMEM_BYTES - 1);
    // A rejected read returns zeros instead of whatever the memory drives
    assign rd_word   = bad_q ? 64'h0 : (is_imem ? {32'h0, rdata_ext} : rdata_ext_2);

    // Next-state, command bookkeeping and strobe generation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        bad_d      = bad_q;
        enable_d   = enable_q;
        err_d      = err_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        wen_ext    = 1'b0;
        wen_ext_2  = 1'b0;
        ren_ext    = 1'b0;
        ren_ext_2  = 1'b0;
        addr_shift = 1'b0;
        data_shift = 1'b0;
        rd_load    = 1'b0;
        rd_shift   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_mem_op(in_data)) begin
                        cmd_d   = in_data;
                        bad_d   = enable_q;
                        cnt_d   = '0;
                        state_d = ST_ADDR;
                        if (enable_q) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        case (in_data)
                            OP_RUN:  enable_d = 1'b1;
                            OP_HALT: enable_d = 1'b0;
                            OP_CLR:  err_d    = 1'b0;
                            default: err_d    = 1'b1;
                        endcase
                    end
                end
            end
            ST_ADDR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    addr_shift = 1'b1;
                    cnt_d      = cnt_q + 4'd1;
                    if (cnt_q == 4'(ADDR_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = is_write ? ST_DATA : ST_RD;
                    end
                end
            end
            ST_DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_shift = 1'b1;
                    cnt_d      = cnt_q + 4'd1;
                    if (cnt_q == last_byte) begin
                        cnt_d   = '0;
                        state_d = ST_WR;
                    end
                end
            end
            ST_WR: begin
                wen_ext   = is_imem & ~bad_q;
                wen_ext_2 = ~is_imem & ~bad_q;
                state_d   = ST_IDLE;
            end
            ST_RD: begin
                ren_ext   = is_imem & ~bad_q;
                ren_ext_2 = ~is_imem & ~bad_q;
                state_d   = ST_RDW;
            end
            ST_RDW: begin
                rd_load = 1'b1;
                cnt_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    rd_shift = 1'b1;
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q == last_byte) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and control registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cmd_q    <= '0;
            bad_q    <= 1'b0;
            enable_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            bad_q    <= bad_d;
            enable_q <= enable_d;
            err_q    <= err_d;
        end
    end

    assign addr_ext    = 64'(addr_q);
    assign addr_ext_2  = 64'(addr_q);
    assign wdata_ext   = wdata_q[63:32];
    assign wdata_ext_2 = wdata_q;
    assign out_data    = rdata_q[7:0];
    assign cpu_enable  = enable_q;
    assign err         = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader with small IMEM/DMEM models.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        inValid;
   logic        inReady;
   logic [7:0]  inData;
   logic        outValid;
   logic        outReady;
   logic [7:0]  outData;
   logic [63:0] addrExt;
   logic        wenExt;
   logic        renExt;
   logic [31:0] wdataExt;
   logic [31:0] rdataExt;
   logic [63:0] addrExt2;
   logic        wenExt2;
   logic        renExt2;
   logic [63:0] wdataExt2;
   logic [63:0] rdataExt2;
   logic        cpuEnable;
   logic        err;

   int checkCount = 0;
   int failCount = 0;

   int          wenCount = 0;
   int          wen2Count = 0;
   int          renCount = 0;
   int          ren2Count = 0;
   logic [63:0] lastAddr = '0;
   logic [31:0] lastWdata = '0;
   logic [63:0] lastAddr2 = '0;
   logic [63:0] lastWdata2 = '0;

   logic [31:0] imem [256];
   logic [63:0] dmem [256];

   prog_loader #(.ADDR_BYTES(2)) dut (
      .clk        (clk),
      .arst_n     (arst_n),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .in_data    (inData),
      .out_valid  (outValid),
      .out_ready  (outReady),
      .out_data   (outData),
      .addr_ext   (addrExt),
      .wen_ext    (wenExt),
      .ren_ext    (renExt),
      .wdata_ext  (wdataExt),
      .rdata_ext  (rdataExt),
      .addr_ext_2 (addrExt2),
      .wen_ext_2  (wenExt2),
      .ren_ext_2  (renExt2),
      .wdata_ext_2(wdataExt2),
      .rdata_ext_2(rdataExt2),
      .cpu_enable (cpuEnable),
      .err        (err)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Synchronous single-cycle-latency memory models
   always @(posedge clk) begin
      if (wenExt) imem[addrExt[7:0]] <= wdataExt;
      if (renExt) rdataExt <= imem[addrExt[7:0]];
      if (wenExt2) dmem[addrExt2[7:0]] <= wdataExt2;
      if (renExt2) rdataExt2 <= dmem[addrExt2[7:0]];
   end

   // Record memory strobes mid-cycle
   always @(negedge clk) begin
      if (wenExt) begin
         wenCount++;
         lastAddr = addrExt;
         lastWdata = wdataExt;
      end
      if (wenExt2) begin
         wen2Count++;
         lastAddr2 = addrExt2;
         lastWdata2 = wdataExt2;
      end
      if (renExt) renCount++;
      if (renExt2) ren2Count++;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Offer one host byte and wait (bounded) until it is accepted
   task automatic applyStimulus(input logic [7:0] b);
      bit done = 0;
      @(negedge clk);
      inValid = 1'b1;
      inData = b;
      for (int i = 0; i < 20 && !done; i++) begin
         if (inReady) begin
            @(posedge clk);
            done = 1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) checkOutput("in_ready_timeout", 64'd0, 64'd1);
      #1 inValid = 1'b0;
   endtask

   // Collect one readback byte (bounded wait) with out_ready pulsed
   task automatic readByte(output logic [7:0] b);
      bit done = 0;
      b = 8'h00;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (outValid) begin
            b = outData;
            outReady = 1'b1;
            @(posedge clk);
            #1 outReady = 1'b0;
            done = 1;
         end
      end
      if (!done) checkOutput("out_valid_timeout", 64'd0, 64'd1);
   endtask

   task automatic sendWri(input logic [15:0] a, input logic [31:0] d);
      applyStimulus(8'h01);
      applyStimulus(a[7:0]);
      applyStimulus(a[15:8]);
      for (int i = 0; i < 4; i++) applyStimulus(d[8*i +: 8]);
   endtask

   initial begin
      logic [7:0]  b;
      logic [7:0]  held;
      logic [63:0] rdExp;
      logic [31:0] riExp;
      int          wenBefore;
      int          renBefore;

      arst_n = 1'b0;
      inValid = 1'b0;
      inData = 8'h00;
      outReady = 1'b0;
      rdataExt = '0;
      rdataExt2 = '0;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_in_ready", 64'(inReady), 64'd1);
      checkOutput("rst_out_valid", 64'(outValid), 64'd0);
      checkOutput("rst_wen", 64'({wenExt, wenExt2, renExt, renExt2}), 64'd0);
      checkOutput("rst_cpu_enable", 64'(cpuEnable), 64'd0);
      checkOutput("rst_err", 64'(err), 64'd0);
      checkOutput("rst_addr", addrExt, 64'd0);
      arst_n = 1'b1;

      // WRI 0x0010 <- 0xDEADBEEF, wen pulse in the cycle after last byte
      sendWri(16'h0010, 32'hDEADBEEF);
      @(negedge clk);
      checkOutput("wri_wen_timing", 64'(wenExt), 64'd1);
      @(negedge clk);
      checkOutput("wri_wen_single", 64'(wenExt), 64'd0);
      checkOutput("wri_wen_count", 64'(wenCount), 64'd1);
      checkOutput("wri_addr", lastAddr, 64'h10);
      checkOutput("wri_data", 64'(lastWdata), 64'hDEADBEEF);
      checkOutput("wri_no_wen2", 64'(wen2Count), 64'd0);

      // WRD 0x0008 <- 0x0123456789ABCDEF
      rdExp = 64'h0123456789ABCDEF;
      applyStimulus(8'h02);
      applyStimulus(8'h08);
      applyStimulus(8'h00);
      for (int i = 0; i < 8; i++) applyStimulus(rdExp[8*i +: 8]);
      @(negedge clk);
      checkOutput("wrd_wen2_timing", 64'(wenExt2), 64'd1);
      checkOutput("wrd_no_wen", 64'(wenExt), 64'd0);
      @(negedge clk);
      checkOutput("wrd_wen2_count", 64'(wen2Count), 64'd1);
      checkOutput("wrd_addr", lastAddr2, 64'h8);
      checkOutput("wrd_data", lastWdata2, 64'h0123456789ABCDEF);

      // RDD 0x0008: ren, one latency cycle, then EF CD AB 89 67 45 23 01
      applyStimulus(8'h04);
      applyStimulus(8'h08);
      applyStimulus(8'h00);
      @(negedge clk);
      checkOutput("rdd_ren2_timing", 64'({renExt, renExt2}), 64'd1);
      @(negedge clk);
      checkOutput("rdd_rdw_no_valid", 64'(outValid), 64'd0);
      for (int i = 0; i < 8; i++) begin
         readByte(b);
         checkOutput($sformatf("rdd_byte%0d", i), 64'(b), 64'(rdExp[8*i +: 8]));
      end

      // RDI 0x0010 with host stalled five cycles, then drained back-to-back
      riExp = 32'hDEADBEEF;
      applyStimulus(8'h03);
      applyStimulus(8'h10);
      applyStimulus(8'h00);
      repeat (3) @(negedge clk);
      checkOutput("rdi_valid_rise", 64'(outValid), 64'd1);
      held = outData;
      checkOutput("rdi_first_byte", 64'(held), 64'hEF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput($sformatf("rdi_hold%0d", i), 64'({outValid, outData}), 64'({1'b1, held}));
      end
      outReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rdi_drain%0d", i), 64'({outValid, outData}), 64'({1'b1, riExp[8*i +: 8]}));
         @(negedge clk);
      end
      outReady = 1'b0;
      checkOutput("rdi_drained", 64'(outValid), 64'd0);

      // RUN then WRI and RDI: rejected, err set, stream stays framed
      applyStimulus(8'h05);
      @(negedge clk);
      checkOutput("run_enable", 64'(cpuEnable), 64'd1);
      wenBefore = wenCount;
      renBefore = renCount;
      sendWri(16'h0020, 32'h44332211);
      repeat (2) @(negedge clk);
      checkOutput("run_wri_no_wen", 64'(wenCount), 64'(wenBefore));
      checkOutput("run_wri_err", 64'(err), 64'd1);
      applyStimulus(8'h03);
      applyStimulus(8'h10);
      applyStimulus(8'h00);
      for (int i = 0; i < 4; i++) begin
         readByte(b);
         checkOutput($sformatf("run_rdi_zero%0d", i), 64'(b), 64'd0);
      end
      checkOutput("run_rdi_no_ren", 64'(renCount), 64'(renBefore));
      applyStimulus(8'h06);
      @(negedge clk);
      checkOutput("halt_enable", 64'(cpuEnable), 64'd0);
      checkOutput("halt_err_kept", 64'(err), 64'd1);
      applyStimulus(8'h07);
      @(negedge clk);
      checkOutput("clr_err", 64'(err), 64'd0);

      // Unknown opcode sets err; next command runs normally
      applyStimulus(8'h5A);
      @(negedge clk);
      checkOutput("bad_op_err", 64'(err), 64'd1);
      checkOutput("bad_op_idle", 64'(inReady), 64'd1);
      wenBefore = wenCount;
      sendWri(16'h0030, 32'h12345678);
      repeat (2) @(negedge clk);
      checkOutput("bad_op_next_wen", 64'(wenCount), 64'(wenBefore + 1));
      checkOutput("bad_op_next_addr", lastAddr, 64'h30);
      checkOutput("bad_op_next_data", 64'(lastWdata), 64'h12345678);
      applyStimulus(8'h07);

      // Reset after two of four data bytes abandons the write
      wenBefore = wenCount;
      applyStimulus(8'h01);
      applyStimulus(8'h40);
      applyStimulus(8'h00);
      applyStimulus(8'hAA);
      applyStimulus(8'hBB);
      @(negedge clk);
      arst_n = 1'b0;
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_no_wen", 64'(wenCount), 64'(wenBefore));
      checkOutput("mid_rst_idle", 64'({inReady, outValid}), 64'b10);
      sendWri(16'h0044, 32'hCAFEF00D);
      repeat (2) @(negedge clk);
      checkOutput("post_rst_wen", 64'(wenCount), 64'(wenBefore + 1));
      checkOutput("post_rst_addr", lastAddr, 64'h44);
      checkOutput("post_rst_data", 64'(lastWdata), 64'hCAFEF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
